muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, start/busy/done handshake.
// Shift-add multiply and restoring divide share a single 64-bit accumulator.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] r
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op;
  logic                neg_a, neg_b;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opnd;

  logic                is_div_in, sa_in, sb_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                b_zero, ovf, special;
  logic [XLEN-1:0]     special_r;

  // Operand decode and special-case detection at the accepting edge
  always_comb begin
    is_div_in = funct3[2];
    sa_in     = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
    sb_in     = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg_in  = sa_in & a[XLEN-1];
    b_neg_in  = sb_in & b[XLEN-1];
    mag_a     = a_neg_in ? ('0 - a) : a;
    mag_b     = b_neg_in ? ('0 - b) : b;
    b_zero    = (b == '0);
    ovf       = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special   = is_div_in && (b_zero || ovf);
    if (b_zero) special_r = funct3[1] ? a : '1;
    else        special_r = funct3[1] ? '0 : a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = special ? DONE : CALC;
      CALC: if (cnt == CNT_W'(XLEN-1)) state_nx = SIGN;
      SIGN: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (kill) state_nx = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_rs;
  logic                div_take;
  logic [XLEN-1:0]     div_diff;
  logic [2*XLEN-1:0]   acc_step;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quot, remv, res;

  // Multiply keeps {hi,lo} with the multiplier consumed from lo; divide keeps {rem,quot}
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    div_rs   = acc[2*XLEN-1:XLEN-1];
    div_take = (div_rs >= {1'b0, opnd});
    div_diff = div_rs[XLEN-1:0] - opnd;
    if (op[2]) begin
      if (div_take) acc_step = {div_diff, acc[XLEN-2:0], 1'b1};
      else          acc_step = {div_rs[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {mul_sum, acc[XLEN-1:1]};
      else        acc_step = {1'b0, acc[2*XLEN-1:1]};
    end
  end

  always_comb begin
    prod = (neg_a ^ neg_b) ? ('0 - acc) : acc;
    quot = (neg_a ^ neg_b) ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
    remv = neg_a ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    unique case (op)
      3'b000:                 res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = quot;
      default:                res = remv;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      op    <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      acc   <= '0;
      opnd  <= '0;
      r     <= '0;
    end else if (!kill) begin
      unique case (state)
        IDLE: if (start) begin
          op    <= funct3;
          neg_a <= a_neg_in;
          neg_b <= b_neg_in;
          cnt   <= '0;
          acc   <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
          opnd  <= is_div_in ? mag_b : mag_a;
          if (special) r <= special_r;
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
        end
        SIGN: r <= res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors against an arithmetic model,
// plus handshake, kill and asynchronous reset scenarios.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] r;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_r = '0;
  logic [31:0] exp_hold = '0;
  bit          mon_en = 1'b0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .done(done), .r(r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, uy, p;
    logic [63:0] up;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    uy = {32'h0, y};
    case (f)
      3'b000: begin p = sx * sy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * uy; return p[63:32]; end
      3'b011: begin up = {32'h0, x} * {32'h0, y}; return up[63:32]; end
      3'b100: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sx / sy; return p[31:0];
      end
      3'b101: return (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 32'h0) return x;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 32'h0) ? x : x % y;
    endcase
  endfunction

  // Whenever done is up the result must match the model; while idle r must hold
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (done) begin
        chk("done_r", r, exp_r);
        chk("done_busy", 32'(busy), 32'd1);
      end else if (!busy) begin
        chk("r_hold", r, exp_hold);
      end
    end
  end

  task automatic run(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] lit, input int lat, input string nm);
    bit seen = 1'b0;
    bit busy_lost = 1'b0;
    chk({nm, "_model"}, model(f, x, y), lit);
    exp_r = model(f, x, y);
    @(negedge clk);
    funct3 = f; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk({nm, "_lat"}, 32'(n), 32'(lat));
        // start while in DONE must be ignored
        start = 1'b1; funct3 = 3'b000; a = 32'h5; b = 32'h6;
      end else begin
        if (!busy) busy_lost = 1'b1;
        if (n == 5) begin
          start = 1'b1; funct3 = 3'b011; a = 32'h11; b = 32'h22;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    chk({nm, "_busy"}, 32'(busy_lost), 32'd0);
    exp_hold = exp_r;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({nm, "_after"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    int dn;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_r", r, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    run(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");
    run(3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, "mulh");
    run(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    run(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
    run(3'b001, 32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFFF, 34, "mulh_neg");
    run(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, "div");
    run(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, "rem");
    run(3'b101, 32'd100,        32'd7,         32'd14,        34, "divu");
    run(3'b111, 32'd100,        32'd7,         32'd2,         34, "remu");
    run(3'b100, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 34, "div_negb");
    run(3'b110, 32'd20,         32'hFFFF_FFFD, 32'd2,         34, "rem_negb");
    run(3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34, "divu_big");
    run(3'b101, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1,  "divu_z");
    run(3'b110, 32'h0000_1234,  32'd0,         32'h0000_1234, 1,  "rem_z");
    run(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
    run(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf");

    // kill partway through a divide
    exp_r = model(3'b101, 32'd1000, 32'd3);
    @(negedge clk);
    funct3 = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    dn = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("kill_quiet", 32'(dn), 32'd0);
    chk("kill_r", r, exp_hold);
    run(3'b111, 32'd1000, 32'd3, 32'd1, 34, "after_kill");

    // asynchronous reset in the middle of a multiply
    exp_r = model(3'b000, 32'h1234, 32'h10);
    @(negedge clk);
    funct3 = 3'b000; a = 32'h1234; b = 32'h10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_hold = '0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3'b000, 32'd3, 32'd5, 32'd15, 34, "mul_after_rst");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
